button_debounce: RTL and testbench

Input-conditioning stage that sits directly upstream of the Wishbone button/LED peripheral and drives its `buttons` input. It synchronises asynchronous pushbutton pins into the `clk` domain and filters contact bounce with a per-button stability counter. It outputs clean debounced levels plus one-cycle press and release pulses. Without this stage, bus reads of the button register would return metastable or bouncing values.

---
 rtl/button_debounce.sv | 109 ++++++++++
 tb/tb_button_debounce.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Conditions raw pushbutton pads for the Wishbone button/LED peripheral. Each
// channel brings its pad into the clk domain through a two-flop synchroniser.
// A stability counter then filters contact bounce: a new level is accepted
// only after the synchronised input has differed from the current stable
// level for DEBOUNCE_CYCLES consecutive cycles. When a new level is accepted,
// the block emits a one-cycle press or release pulse.
//
// Parameters
//   NUM_BUTTONS     number of independent channels (>= 1)
//   DEBOUNCE_CYCLES consecutive mismatch cycles required to accept a change
//                   (>= 1; 250000 gives 10 ms at 25 MHz)
//   CNT_W           width of each stability counter
//
// Ports
//   clk            rising-edge clock for all state
//   reset          asynchronous, active-high; clears every flop immediately
//   buttons_raw    raw pad inputs, asynchronous to clk, active-high
//   buttons        debounced level per channel (registered)
//   press_pulse    one-cycle pulse when the debounced level goes 0->1
//   release_pulse  one-cycle pulse when the debounced level goes 1->0
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int NUM_BUTTONS     = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse
);

  // Terminal count: a mismatch seen while the counter holds this value is the
  // DEBOUNCE_CYCLES-th consecutive one, so the new level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Saturating increment. The acceptance branch already stops the count at
  // CNT_LAST. The clamp here also guarantees the counter can never wrap.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] nxt;
    if (cnt >= CNT_LAST) begin
      nxt = CNT_LAST;
    end else begin
      nxt = cnt + 1'b1;
    end
    return nxt;
  endfunction

  logic [NUM_BUTTONS-1:0]            sync1_q, sync1_d;
  logic [NUM_BUTTONS-1:0]            sync2_q, sync2_d;
  logic [NUM_BUTTONS-1:0]            btn_q, btn_d;
  logic [NUM_BUTTONS-1:0]            press_q, press_d;
  logic [NUM_BUTTONS-1:0]            rel_q, rel_d;
  logic [NUM_BUTTONS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // Synchroniser chain: raw pad -> sync1 -> sync2. Only sync2 is used by
    // the filter, which keeps a possibly metastable sync1 out of the logic.
    sync1_d = buttons_raw;
    sync2_d = sync1_q;
    btn_d   = btn_q;
    cnt_d   = cnt_q;
    press_d = '0;
    rel_d   = '0;

    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (sync2_q[i] == btn_q[i]) begin
        // Any cycle that agrees with the stable level restarts the interval.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        // Input has disagreed for the full interval: accept it.
        btn_d[i]   = sync2_q[i];
        cnt_d[i]   = '0;
        press_d[i] = sync2_q[i];
        rel_d[i]   = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_inc(cnt_q[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      btn_q   <= '0;
      cnt_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      btn_q   <= btn_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign buttons       = btn_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] buttons_raw = 3'b111;
  logic [2:0] buttons, press_pulse, release_pulse;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [2:0] b;
    logic [2:0] p;
    logic [2:0] r;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  button_debounce #(
    .NUM_BUTTONS    (3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .buttons_raw  (buttons_raw),
    .buttons      (buttons),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got b/p/r=%b_%b_%b expected %b_%b_%b", name, cyc,
               act[8:6], act[5:3], act[2:0], exp[8:6], exp[5:3], exp[2:0]);
    end
  endtask

  task automatic expect_at(input int c, input logic [2:0] b, input logic [2:0] p,
                           input logic [2:0] r, input string name);
    exp_t e;
    e.cyc = c; e.b = b; e.p = p; e.r = r; e.name = name;
    sb_q.push_back(e);
  endtask

  // Advance to just after the next rising edge; returns the edge index.
  task automatic step(output int c);
    @(posedge clk);
    #1;
    c = cyc;
  endtask

  task automatic wait_edges(input int n);
    int c;
    for (int i = 0; i < n; i++) step(c);
  endtask

  // Monitor: compares the registered outputs, sampled on the falling edge,
  // against every scoreboard entry due at the current edge index.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: expectation for cycle %0d missed, now %0d", e.name, e.cyc, cyc);
      end else begin
        check(e.name, {buttons, press_pulse, release_pulse}, {e.b, e.p, e.r});
      end
    end
  end

  initial begin
    int c;

    // Reset held with all pads pressed: outputs stay 0.
    step(c);
    for (int i = 1; i <= 4; i++) expect_at(c + i, 3'b000, 3'b000, 3'b000, "rst_hold");
    wait_edges(5);
    buttons_raw = 3'b000;
    reset = 1'b0;
    wait_edges(4);

    // Clean press on channel 0: first sampled at c+1, accepted at c+6.
    step(c);
    buttons_raw = 3'b001;
    expect_at(c + 5, 3'b000, 3'b000, 3'b000, "press0_early");
    expect_at(c + 6, 3'b001, 3'b001, 3'b000, "press0_edge");
    expect_at(c + 7, 3'b001, 3'b000, 3'b000, "press0_pulse_end");
    wait_edges(9);

    // Bounce on channel 1: 1,0,1,0,1 then hold. Last 0->1 sampled at c+5.
    step(c);
    for (int i = 1; i <= 9; i++) expect_at(c + i, 3'b001, 3'b000, 3'b000, "bounce1_quiet");
    expect_at(c + 10, 3'b011, 3'b010, 3'b000, "bounce1_press");
    expect_at(c + 11, 3'b011, 3'b000, 3'b000, "bounce1_pulse_end");
    buttons_raw = 3'b011; step(c);
    buttons_raw = 3'b001; step(c);
    buttons_raw = 3'b011; step(c);
    buttons_raw = 3'b001; step(c);
    buttons_raw = 3'b011;
    wait_edges(9);

    // Bring channel 2 high.
    step(c);
    buttons_raw = 3'b111;
    expect_at(c + 6, 3'b111, 3'b100, 3'b000, "press2_edge");
    expect_at(c + 7, 3'b111, 3'b000, 3'b000, "press2_pulse_end");
    wait_edges(9);

    // Sub-threshold glitch: channel 2 low for 3 cycles only.
    step(c);
    for (int i = 1; i <= 11; i++) expect_at(c + i, 3'b111, 3'b000, 3'b000, "glitch2_reject");
    buttons_raw = 3'b011;
    wait_edges(3);
    buttons_raw = 3'b111;
    wait_edges(10);

    // Release channel 2 so it can be pressed again below.
    step(c);
    buttons_raw = 3'b011;
    expect_at(c + 6, 3'b011, 3'b000, 3'b100, "release2_edge");
    expect_at(c + 7, 3'b011, 3'b000, 3'b000, "release2_pulse_end");
    wait_edges(9);

    // Release channel 0 and press channel 2 on the same edge.
    step(c);
    buttons_raw = 3'b110;
    expect_at(c + 5, 3'b011, 3'b000, 3'b000, "indep_early");
    expect_at(c + 6, 3'b110, 3'b100, 3'b001, "indep_edge");
    expect_at(c + 7, 3'b110, 3'b000, 3'b000, "indep_pulse_end");
    wait_edges(9);

    // Asynchronous reset mid-count clears outputs without a clock edge.
    step(c);
    buttons_raw = 3'b000;
    wait_edges(3);
    check("pre_async_rst", {buttons, press_pulse, release_pulse}, 9'b110_000_000);
    #1 reset = 1'b1;
    #1 check("async_rst_clear", {buttons, press_pulse, release_pulse}, 9'b000_000_000);
    buttons_raw = 3'b001;
    wait_edges(2);
    check("rst_held_pressed", {buttons, press_pulse, release_pulse}, 9'b000_000_000);

    // Button 0 held through reset: reported as a fresh press.
    step(c);
    reset = 1'b0;
    expect_at(c + 5, 3'b000, 3'b000, 3'b000, "held_early");
    expect_at(c + 6, 3'b001, 3'b001, 3'b000, "held_press");
    expect_at(c + 7, 3'b001, 3'b000, 3'b000, "held_pulse_end");
    wait_edges(10);

    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left unchecked", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
